qam_demapper: RTL and testbench

//  Soft max-log demapper for Gray rectangular QAM, 1..10 bits/symbol (BPSK..QAM1024).

---
 rtl/qam_demapper_pkg.sv | 43 ++++
 rtl/qam_demapper_axis.sv | 53 +++++
 rtl/qam_demapper.sv | 164 ++++++++++++++++
 tb/tb_qam_demapper.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_demapper_pkg.sv
// Shared constants, types and helpers for the Gray rectangular QAM soft demapper.
// The optional output stage is selected with the QAM_DEMAPPER_OREG_EN macro (see qam_demapper.sv).
package qam_demapper_pkg;

    localparam int unsigned cMAX_BITS = 10;  // largest supported bits/symbol (QAM1024)
    localparam int unsigned cLLR_N    = 10;  // number of LLR output lanes
    localparam int unsigned cAXIS_N   = 5;   // largest bit count on one PAM axis
    localparam int unsigned cQAM_W    = 4;   // width of the bits/symbol field
    localparam int unsigned cK_W      = 3;   // width of a per-axis bit count
    localparam int unsigned cLLR_W    = 4;   // default LLR width

    typedef logic signed [cLLR_W-1:0] llr_t;

    // Clamp requested bits/symbol to the supported maximum
    function automatic logic [cQAM_W-1:0] clamp_qam(input logic [cQAM_W-1:0] m);
        return (m > cQAM_W'(cMAX_BITS)) ? cQAM_W'(cMAX_BITS) : m;
    endfunction

    // Split m into {Kr, Ki}: ceil(m/2) bits on the real axis, floor(m/2) on the imaginary axis
    function automatic logic [2*cK_W-1:0] axis_bits(input logic [cQAM_W-1:0] m);
        logic [cQAM_W:0] m1;
        logic [cK_W-1:0] kr;
        logic [cK_W-1:0] ki;
        m1 = {1'b0, m} + (cQAM_W+1)'(1);
        kr = cK_W'(m1 >> 1);
        ki = cK_W'(m >> 1);
        return {kr, ki};
    endfunction

    // Symmetric saturation to +-(2^(w-1)-1)
    function automatic int sat_llr(input int s, input int unsigned w);
        int lim;
        lim = (1 << (w - 1)) - 1;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/qam_demapper_axis.sv
// One PAM axis of the max-log demapper: k bits (0..5) from a signed sample, combinational.
// llr_o_c[b] is the LLR of local axis bit b (b = k-1 is the axis MSB); lanes b >= k are zero.
module qam_demapper_axis
    import qam_demapper_pkg::*;
#(
    parameter int unsigned pDAT_W = 8,
    parameter int unsigned pLLR_W = 4
) (
    input  logic [cK_W-1:0]          k_i,
    input  logic signed [pDAT_W-1:0] dat_i,
    output logic signed [pLLR_W-1:0] llr_o_c [cAXIS_N]
);

    localparam int unsigned cRES_W = pDAT_W + 2;
    localparam int          cGAIN  = 1 << (pLLR_W - 2);

    logic signed [cRES_W-1:0] res_c [cAXIS_N];
    logic signed [pLLR_W-1:0] sat_c [cAXIS_N];
    int unsigned              shift_c;

    function automatic logic signed [cRES_W-1:0] mag(input logic signed [cRES_W-1:0] v);
        return v[cRES_W-1] ? -v : v;
    endfunction

    // Shift converting a residual to LLR units depends on the live axis size
    assign shift_c = (pDAT_W - 1) - 32'(k_i);

    // Residual chain: D*2^(k-j) collapses to 2^(pDAT_W-1-j), so the chain itself is k-independent
    always_comb begin
        res_c[0] = cRES_W'(dat_i);
        for (int j = 1; j < cAXIS_N; j++) begin
            res_c[j] = cRES_W'(1 << (pDAT_W - 1 - j)) - mag(res_c[j-1]);
        end
    end

    // Scale (floor via arithmetic shift) and saturate every residual
    always_comb begin
        for (int j = 0; j < cAXIS_N; j++) begin
            sat_c[j] = pLLR_W'(sat_llr((int'(res_c[j]) * cGAIN) >>> shift_c, pLLR_W));
        end
    end

    // Residual j drives axis bit k-1-j
    always_comb begin
        for (int b = 0; b < cAXIS_N; b++) begin
            llr_o_c[b] = '0;
            if (b < int'(k_i)) begin
                llr_o_c[b] = sat_c[cK_W'(int'(k_i) - 1 - b)];
            end
        end
    end

endmodule

// File: rtl/qam_demapper.sv
// Soft max-log demapper for Gray rectangular QAM, 1..10 bits/symbol, one sample per cycle.
// Stage 1 registers the clamped m and the sample; stage 2 registers the packed LLRs.
// Macro QAM_DEMAPPER_OREG_EN adds a third (output) register stage.
module qam_demapper
    import qam_demapper_pkg::*;
#(
    parameter int unsigned pDAT_W = 8,
    parameter int unsigned pLLR_W = 4
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     ival,
    input  logic                     isop,
    input  logic [cQAM_W-1:0]        iqam,
    input  logic signed [pDAT_W-1:0] idat_re,
    input  logic signed [pDAT_W-1:0] idat_im,
    output logic                     oval,
    output logic                     osop,
    output logic [cQAM_W-1:0]        oqam,
    output logic signed [pLLR_W-1:0] oLLR [cLLR_N]
);

    logic [cQAM_W-1:0]        qam_d;
    logic [cK_W-1:0]          kr_d;
    logic [cK_W-1:0]          ki_d;

    logic                     s1_val_q;
    logic                     s1_sop_q;
    logic [cQAM_W-1:0]        s1_qam_q;
    logic [cK_W-1:0]          s1_kr_q;
    logic [cK_W-1:0]          s1_ki_q;
    logic signed [pDAT_W-1:0] s1_re_q;
    logic signed [pDAT_W-1:0] s1_im_q;

    logic signed [pLLR_W-1:0] re_llr_c [cAXIS_N];
    logic signed [pLLR_W-1:0] im_llr_c [cAXIS_N];
    logic signed [pLLR_W-1:0] llr_d    [cLLR_N];

    logic                     s2_val_q;
    logic                     s2_sop_q;
    logic [cQAM_W-1:0]        s2_qam_q;
    logic signed [pLLR_W-1:0] s2_llr_q [cLLR_N];

    // Clamp m and split it across the two axes
    always_comb begin
        qam_d          = clamp_qam(iqam);
        {kr_d, ki_d}   = axis_bits(qam_d);
    end

    // Stage 1: valid always advances, payload only on valid samples
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            s1_val_q <= 1'b0;
            s1_sop_q <= 1'b0;
            s1_qam_q <= '0;
            s1_kr_q  <= '0;
            s1_ki_q  <= '0;
            s1_re_q  <= '0;
            s1_im_q  <= '0;
        end else if (iclkena) begin
            s1_val_q <= ival;
            if (ival) begin
                s1_sop_q <= isop;
                s1_qam_q <= qam_d;
                s1_kr_q  <= kr_d;
                s1_ki_q  <= ki_d;
                s1_re_q  <= idat_re;
                s1_im_q  <= idat_im;
            end
        end
    end

    qam_demapper_axis #(
        .pDAT_W (pDAT_W),
        .pLLR_W (pLLR_W)
    ) u_axis_re (
        .k_i     (s1_kr_q),
        .dat_i   (s1_re_q),
        .llr_o_c (re_llr_c)
    );

    qam_demapper_axis #(
        .pDAT_W (pDAT_W),
        .pLLR_W (pLLR_W)
    ) u_axis_im (
        .k_i     (s1_ki_q),
        .dat_i   (s1_im_q),
        .llr_o_c (im_llr_c)
    );

    // Pack: real-axis bits in lanes [0..Kr-1], imaginary-axis bits in [Kr..Kr+Ki-1]
    always_comb begin
        for (int i = 0; i < cLLR_N; i++) begin
            llr_d[i] = '0;
        end
        for (int b = 0; b < cAXIS_N; b++) begin
            if (b < int'(s1_kr_q)) begin
                llr_d[b] = re_llr_c[b];
            end
        end
        for (int b = 0; b < cAXIS_N; b++) begin
            if (b < int'(s1_ki_q)) begin
                llr_d[cQAM_W'(int'(s1_kr_q) + b)] = im_llr_c[b];
            end
        end
    end

    // Stage 2: results update only on valid samples and hold otherwise
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            s2_val_q <= 1'b0;
            s2_sop_q <= 1'b0;
            s2_qam_q <= '0;
            for (int i = 0; i < cLLR_N; i++) begin
                s2_llr_q[i] <= '0;
            end
        end else if (iclkena) begin
            s2_val_q <= s1_val_q;
            if (s1_val_q) begin
                s2_sop_q <= s1_sop_q;
                s2_qam_q <= s1_qam_q;
                s2_llr_q <= llr_d;
            end
        end
    end

`ifdef QAM_DEMAPPER_OREG_EN
    logic                     s3_val_q;
    logic                     s3_sop_q;
    logic [cQAM_W-1:0]        s3_qam_q;
    logic signed [pLLR_W-1:0] s3_llr_q [cLLR_N];

    // Optional output stage: plain retiming of stage 2
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            s3_val_q <= 1'b0;
            s3_sop_q <= 1'b0;
            s3_qam_q <= '0;
            for (int i = 0; i < cLLR_N; i++) begin
                s3_llr_q[i] <= '0;
            end
        end else if (iclkena) begin
            s3_val_q <= s2_val_q;
            if (s2_val_q) begin
                s3_sop_q <= s2_sop_q;
                s3_qam_q <= s2_qam_q;
                s3_llr_q <= s2_llr_q;
            end
        end
    end

    assign oval = s3_val_q;
    assign osop = s3_sop_q;
    assign oqam = s3_qam_q;
    assign oLLR = s3_llr_q;
`else
    assign oval = s2_val_q;
    assign osop = s2_sop_q;
    assign oqam = s2_qam_q;
    assign oLLR = s2_llr_q;
`endif

endmodule

// File: tb/tb_qam_demapper.sv
// Directed-vector bench for qam_demapper: exact-LLR table, full constellation sweep,
// clock-enable freeze and mid-stream reset sequences.
module tb_qam_demapper;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
`ifdef QAM_DEMAPPER_OREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                 iclk;
    logic                 ireset;
    logic                 iclkena;
    logic                 ival;
    logic                 isop;
    logic [3:0]           iqam;
    logic signed [DW-1:0] idat_re;
    logic signed [DW-1:0] idat_im;
    logic                 oval;
    logic                 osop;
    logic [3:0]           oqam;
    logic signed [LW-1:0] oLLR [10];

    qam_demapper #(
        .pDAT_W (DW),
        .pLLR_W (LW)
    ) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (ival),
        .isop    (isop),
        .iqam    (iqam),
        .idat_re (idat_re),
        .idat_im (idat_im),
        .oval    (oval),
        .osop    (osop),
        .oqam    (oqam),
        .oLLR    (oLLR)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic [3:0]  qam;
        logic        sop;
        logic        exact;
        logic [39:0] llr;
        logic [9:0]  bits;
    } exp_t;

    typedef struct {
        logic [3:0]         qam;
        logic signed [7:0]  re;
        logic signed [7:0]  im;
        logic [3:0]         eqam;
        logic [39:0]        ellr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    logic upd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [39:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7,
                                       input int a8, input int a9);
        return {4'(a9), 4'(a8), 4'(a7), 4'(a6), 4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    function automatic vec_t mkv(input int q, input int re, input int im, input int eq,
                                 input logic [39:0] l);
        vec_t v;
        v.qam = 4'(q); v.re = 8'(re); v.im = 8'(im); v.eqam = 4'(eq); v.ellr = l;
        return v;
    endfunction

    function automatic exp_t vexp(input vec_t v, input logic sop);
        exp_t e;
        e.qam = v.eqam; e.sop = sop; e.exact = 1'b1; e.llr = v.ellr; e.bits = '0;
        return e;
    endfunction

    // Gray rectangular reference mapper for one axis: Gray label g -> ideal level
    function automatic logic signed [7:0] lvl(input int k, input int g);
        int t;
        int b;
        int d;
        t = 0;
        b = 0;
        for (int i = k - 1; i >= 0; i--) begin
            b = b ^ ((g >> i) & 1);
            t = t | (b << i);
        end
        d = 1 << (DW - 1 - k);
        return 8'(d * (2 * t + 1 - (1 << k)));
    endfunction

    task automatic drive(input logic [3:0] q, input logic signed [7:0] re,
                         input logic signed [7:0] im, input logic sop, input exp_t e);
        ival = 1'b1; isop = sop; iqam = q; idat_re = re; idat_im = im;
        sb.push_back(e);
        @(posedge iclk);
        #1;
        ival = 1'b0;
        isop = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (LAT + 2) begin
            @(posedge iclk);
            #1;
        end
        chk(name, 64'(sb.size()), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        logic [39:0] al;
        for (int i = 0; i < 10; i++) al[i*4 +: 4] = oLLR[i];
        chk({tag, "_oval"}, 64'(oval), 64'(0));
        chk({tag, "_osop"}, 64'(osop), 64'(0));
        chk({tag, "_oqam"}, 64'(oqam), 64'(0));
        chk({tag, "_llr"},  64'(al),   64'(0));
    endtask

    // Records whether the last rising edge was enabled
    initial begin
        forever begin
            @(posedge iclk);
            upd = iclkena;
        end
    end

    // Output monitor: one scoreboard entry per enabled valid output
    initial begin
        exp_t        e;
        logic [39:0] al;
        logic [9:0]  ab;
        forever begin
            @(negedge iclk);
            if (ireset && upd && oval) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_oval: got oval=1, expected no pending sample");
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 10; i++) begin
                        al[i*4 +: 4] = oLLR[i];
                        ab[i] = (i < int'(e.qam)) ? ~oLLR[i][LW-1] : (oLLR[i] != 0);
                    end
                    if (e.exact) chk($sformatf("llr_m%0d", e.qam), 64'(al), 64'(e.llr));
                    else         chk($sformatf("hard_m%0d", e.qam), 64'(ab), 64'(e.bits));
                    chk($sformatf("oqam_m%0d", e.qam), 64'(oqam), 64'(e.qam));
                    chk($sformatf("osop_m%0d", e.qam), 64'(osop), 64'(e.sop));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        logic [39:0] al;
        int          cyc;
        int          kr;
        int          ki;
        logic signed [7:0] re;
        logic signed [7:0] im;

        vecs[0] = mkv(2,   64,  -64,  2, pk( 4, -4,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[1] = mkv(4,   96,   32,  4, pk(-4,  7,  4,  4,  0,  0,  0,  0,  0,  0));
        vecs[2] = mkv(1,  -64,  100,  1, pk(-4,  0,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[3] = mkv(10, 127, -128, 10, pk(-7, -7, -7, -7,  7, -7, -7, -7, -7, -7));
        vecs[4] = mkv(1,   20,  -77,  1, pk( 1,  0,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[5] = mkv(15, 127, -128, 10, pk(-7, -7, -7, -7,  7, -7, -7, -7, -7, -7));
        vecs[6] = mkv(1,  -20,    0,  1, pk(-2,  0,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[7] = mkv(0,   50,  -20,  0, pk( 0,  0,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[8] = mkv(3, -100,   10,  3, pk(-5, -7,  0,  0,  0,  0,  0,  0,  0,  0));
        vecs[9] = mkv(6,    0,   -1,  6, pk(-7,  7,  0, -7,  7, -1,  0,  0,  0,  0));

        ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0;
        iqam = '0; idat_re = '0; idat_im = '0;
        #1 ireset = 1'b0;
        #2 chk_zero("reset");
        repeat (2) @(posedge iclk);
        #1 ireset = 1'b1;

        // Latency from ival to oval
        drive(vecs[0].qam, vecs[0].re, vecs[0].im, 1'b1, vexp(vecs[0], 1'b1));
        cyc = 1;
        while (oval !== 1'b1 && cyc < 10) begin
            @(posedge iclk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(LAT));
        drain("drain_lat");

        // Exact-LLR table, back to back (m alternates 1/10 in the middle)
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].qam, vecs[i].re, vecs[i].im, i == 0, vexp(vecs[i], i == 0));
        end
        drain("drain_table");

        // All symbols of every constellation through the reference mapper
        for (int m = 1; m <= 10; m++) begin
            kr = (m + 1) / 2;
            ki = m / 2;
            for (int s = 0; s < (1 << m); s++) begin
                re = lvl(kr, s & ((1 << kr) - 1));
                im = (ki > 0) ? lvl(ki, s >> kr) : 8'($urandom_range(0, 255));
                e.qam = 4'(m); e.sop = (s == 0); e.exact = 1'b0; e.llr = '0; e.bits = 10'(s);
                drive(4'(m), re, im, s == 0, e);
            end
        end
        drain("drain_sweep");

        // Clock-enable low for 3 cycles: outputs frozen on the first sample, nothing lost
        drive(vecs[1].qam, vecs[1].re, vecs[1].im, 1'b1, vexp(vecs[1], 1'b1));
        for (int k = 1; k < LAT; k++) begin
            drive(vecs[1+k].qam, vecs[1+k].re, vecs[1+k].im, 1'b0, vexp(vecs[1+k], 1'b0));
        end
        iclkena = 1'b0;
        ival = 1'b1; isop = 1'b0; iqam = vecs[9].qam; idat_re = vecs[9].re; idat_im = vecs[9].im;
        repeat (3) begin
            @(posedge iclk);
            #1;
            for (int i = 0; i < 10; i++) al[i*4 +: 4] = oLLR[i];
            chk("frz_oval", 64'(oval), 64'(1));
            chk("frz_oqam", 64'(oqam), 64'(vecs[1].eqam));
            chk("frz_llr",  64'(al),   64'(vecs[1].ellr));
        end
        sb.push_back(vexp(vecs[9], 1'b0));
        iclkena = 1'b1;
        @(posedge iclk);
        #1;
        ival = 1'b0;
        drain("drain_clkena");

        // Asynchronous reset mid-stream, then restart
        drive(vecs[3].qam, vecs[3].re, vecs[3].im, 1'b1, vexp(vecs[3], 1'b1));
        drive(vecs[9].qam, vecs[9].re, vecs[9].im, 1'b0, vexp(vecs[9], 1'b0));
        #3 ireset = 1'b0;
        #1 chk_zero("midrst");
        sb.delete();
        @(posedge iclk);
        #1 ireset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].qam, vecs[i].re, vecs[i].im, i == 0, vexp(vecs[i], i == 0));
        end
        drain("drain_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
